sfu_seq_ctrl: RTL and testbench

- Sequencer for the SFU accumulate/ReLU datapath.
- Pops psum vectors from the OFIFO and drives the SFU acc/bypass controls for every vector.
- Writes each finished output pixel into PMEM at sequential addresses.
- Two modes: accumulate K kernel-position psums per pixel then ReLU, or bypass (each raw psum vector stored directly).

---
 rtl/sfu_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_sfu_seq_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sfu_seq_ctrl.sv
// Sequencer for the SFU accumulate/ReLU datapath: pops OFIFO psums, drives SFU acc/bypass, writes PMEM.
// Optional macro SFU_SEQ_CTRL_PERF_EN adds the perf_stall counter output.
module sfu_seq_ctrl #(
    parameter int addr_bw = 11,
    parameter int kpos_bw = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               cfg_mode,
    input  logic [kpos_bw-1:0] cfg_kpos,
    input  logic [addr_bw-1:0] cfg_npix,
    input  logic [addr_bw-1:0] cfg_base,
    input  logic               ofifo_valid,
    output logic               ofifo_rd,
    output logic               sfu_psum_valid,
    output logic               sfu_acc,
    output logic               sfu_bypass,
    output logic               pmem_wen,
    output logic [addr_bw-1:0] pmem_addr,
    output logic               busy,
    output logic               done
`ifdef SFU_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_mode;
    logic [kpos_bw-1:0] r_kpos;
    logic [kpos_bw-1:0] r_kcnt;
    logic [addr_bw-1:0] r_npix;
    logic [addr_bw-1:0] r_base;
    logic [addr_bw-1:0] r_pcnt;
    logic               r_pmem_wen;
    logic [addr_bw-1:0] r_pmem_addr;

    logic w_start_ok;
    logic w_pop;
    logic w_kpos_last;
    logic w_pix_done;
    logic w_run_last;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        w_start_ok   = (r_state == IDLE) & start;
        w_pop        = (r_state == RUN) & ofifo_valid;
        w_kpos_last  = (r_kcnt == r_kpos - kpos_bw'(1));
        w_pix_done   = w_pop & (r_mode | w_kpos_last);
        w_run_last   = w_pix_done & (r_pcnt == r_npix - addr_bw'(1));
        w_next_state = r_state;

        case (r_state)
            // An empty run still passes through DRAIN so done keeps its 2-cycle latency from start.
            IDLE:    if (w_start_ok) w_next_state = (cfg_npix == '0) ? DRAIN : RUN;
            RUN:     if (w_run_last) w_next_state = DRAIN;
            DRAIN:   w_next_state = FIN;
            FIN:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase

        // acc drops only on a pixel-completing pop: ReLU+clear in accumulate mode, raw pass in bypass.
        ofifo_rd       = w_pop;
        sfu_psum_valid = w_pop;
        sfu_acc        = ~w_pix_done;
        sfu_bypass     = r_mode & w_pop;
        busy           = (r_state != IDLE);
        done           = (r_state == FIN);
    end

    assign pmem_wen  = r_pmem_wen;
    assign pmem_addr = r_pmem_addr;

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled synchronously.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_mode      <= 1'b0;
            r_kpos      <= '0;
            r_kcnt      <= '0;
            r_npix      <= '0;
            r_base      <= '0;
            r_pcnt      <= '0;
            r_pmem_wen  <= 1'b0;
            r_pmem_addr <= '0;
        end else begin
            r_state    <= w_next_state;
            r_pmem_wen <= w_pix_done;
            if (w_pix_done) r_pmem_addr <= r_base + r_pcnt;

            if (w_start_ok) begin
                r_mode <= cfg_mode;
                r_kpos <= (cfg_kpos == '0) ? kpos_bw'(1) : cfg_kpos;
                r_npix <= cfg_npix;
                r_base <= cfg_base;
                r_kcnt <= '0;
                r_pcnt <= '0;
            end else if (w_pop) begin
                if (!r_mode) r_kcnt <= w_kpos_last ? '0 : r_kcnt + kpos_bw'(1);
                if (w_pix_done) r_pcnt <= r_pcnt + addr_bw'(1);
            end
        end
    end

`ifdef SFU_SEQ_CTRL_PERF_EN
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf_stall <= '0;
        end else if (w_start_ok) begin
            r_perf_stall <= '0;
        end else if ((r_state == RUN) && !ofifo_valid && (r_perf_stall != '1)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_sfu_seq_ctrl.sv
// Self-checking bench for sfu_seq_ctrl: randomized runs against a pop-count/pixel-level reference
// model, with a behavioural SFU lane so PMEM data (ReLU sums / bypass values) is checked too.
module tb_sfu_seq_ctrl;

    localparam int AW = 11;
    localparam int KW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          cfg_mode = 1'b0;
    logic [KW-1:0] cfg_kpos = '0;
    logic [AW-1:0] cfg_npix = '0;
    logic [AW-1:0] cfg_base = '0;
    logic          ofifo_valid = 1'b0;
    logic          ofifo_rd;
    logic          sfu_psum_valid;
    logic          sfu_acc;
    logic          sfu_bypass;
    logic          pmem_wen;
    logic [AW-1:0] pmem_addr;
    logic          busy;
    logic          done;
`ifdef SFU_SEQ_CTRL_PERF_EN
    logic [31:0]   perf_stall;
`endif

    sfu_seq_ctrl #(.addr_bw(AW), .kpos_bw(KW)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cfg_mode       (cfg_mode),
        .cfg_kpos       (cfg_kpos),
        .cfg_npix       (cfg_npix),
        .cfg_base       (cfg_base),
        .ofifo_valid    (ofifo_valid),
        .ofifo_rd       (ofifo_rd),
        .sfu_psum_valid (sfu_psum_valid),
        .sfu_acc        (sfu_acc),
        .sfu_bypass     (sfu_bypass),
        .pmem_wen       (pmem_wen),
        .pmem_addr      (pmem_addr),
        .busy           (busy),
        .done           (done)
`ifdef SFU_SEQ_CTRL_PERF_EN
        ,
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int relu(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    // Behavioural SFU lane 0 plus the OFIFO contents it reads from.
    int psum_q[$];
    int dir_psum[$];
    int sfu_accum = 0;
    int sfp_out = 0;
    int m_p;

    always @(posedge clk) begin
        m_p = (sfu_psum_valid && psum_q.size() > 0) ? psum_q[0] : 0;
        if (!reset) begin
            sfu_accum = 0;
            sfp_out   = 0;
        end else begin
            if (sfu_bypass) sfp_out = m_p;
            else if (!sfu_acc) begin
                sfp_out   = relu(sfu_accum + m_p);
                sfu_accum = 0;
            end else sfu_accum = sfu_accum + m_p;
            if (ofifo_rd && psum_q.size() > 0) void'(psum_q.pop_front());
        end
    end

    int last_addr = 0;

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 32'({ofifo_rd, sfu_psum_valid, sfu_acc, sfu_bypass, pmem_wen, busy, done}),
              32'(7'b0010000));
        check({tag, "_addr"}, 32'(pmem_addr), 32'd0);
    endtask

    task automatic run(input bit mode, input int kpos, input int npix, input int base,
                       input int stall_pct, input int gap_after, input int gap_len,
                       input bit spurious, input int abort_pops);
        int  keff, total, pops, done_c, gap_used, stalls, sum;
        bit  wen_due, running, exp_rd, pix_done, finished;
        int  vals[$];
        int  exp_addr_q[$];
        int  exp_data_q[$];

        keff  = (kpos == 0) ? 1 : kpos;
        total = mode ? npix : npix * keff;
        vals.delete();
        for (int i = 0; i < total; i++)
            vals.push_back((dir_psum.size() > i) ? dir_psum[i] : int'($urandom_range(0, 200)) - 100);
        for (int p = 0; p < npix; p++) begin
            sum = 0;
            if (mode) sum = vals[p];
            else for (int j = 0; j < keff; j++) sum += vals[p * keff + j];
            exp_addr_q.push_back((base + p) % (1 << AW));
            exp_data_q.push_back(mode ? sum : relu(sum));
        end
        psum_q = vals;

        @(posedge clk); #1;
        cfg_mode = mode; cfg_kpos = KW'(kpos); cfg_npix = AW'(npix); cfg_base = AW'(base);
        start = 1'b1; ofifo_valid = 1'b0;
        @(negedge clk);
        check("busy_before_start", 32'(busy), 32'd0);

        pops = 0; done_c = (total == 0) ? 2 : -1; wen_due = 0; gap_used = 0; stalls = 0; finished = 0;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk); #1;
            start = spurious && (c == 2 || c == done_c);
            if (start) begin
                cfg_mode = ~mode; cfg_npix = AW'($urandom); cfg_base = AW'($urandom); cfg_kpos = KW'($urandom);
            end
            running = (pops < total);
            if (running && pops >= gap_after && gap_used < gap_len) begin
                ofifo_valid = 1'b0;
                gap_used++;
            end else ofifo_valid = ($urandom_range(0, 99) >= stall_pct);

            @(negedge clk);
            exp_rd   = running && ofifo_valid;
            pix_done = exp_rd && (mode || ((pops % keff) == keff - 1));
            check("ctrl_rd_pv_acc_byp", 32'({ofifo_rd, sfu_psum_valid, sfu_acc, sfu_bypass}),
                  32'({exp_rd, exp_rd, ~pix_done, mode & exp_rd}));
            check("pmem_wen", 32'(pmem_wen), 32'(wen_due));
            if (wen_due && exp_addr_q.size() > 0) begin
                check("pmem_addr", 32'(pmem_addr), 32'(exp_addr_q[0]));
                check("pmem_data", 32'(sfp_out), 32'(exp_data_q[0]));
                last_addr = exp_addr_q.pop_front();
                void'(exp_data_q.pop_front());
            end else check("pmem_addr_hold", 32'(pmem_addr), 32'(last_addr));
            check("busy", 32'(busy), 32'((done_c < 0) || (c <= done_c)));
            check("done", 32'(done), 32'(c == done_c));
`ifdef SFU_SEQ_CTRL_PERF_EN
            if (c == 1) check("perf_cleared", perf_stall, 32'd0);
`endif
            if (running && !ofifo_valid) stalls++;
            wen_due = pix_done;
            if (exp_rd) begin
                pops++;
                if (pops == total) done_c = c + 2;
            end
            if (abort_pops > 0 && pops == abort_pops) begin
                reset = 1'b0;
                @(posedge clk); #1;
                ofifo_valid = 1'b1;
                @(negedge clk);
                check_reset_outputs("abort");
                last_addr = 0;
                reset = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("abort_idle", 32'({ofifo_rd, pmem_wen, busy}), 32'd0);
                end
                ofifo_valid = 1'b0;
                psum_q.delete();
                return;
            end
            if (c == done_c) begin
                finished = 1;
                break;
            end
        end
        check("run_finished", 32'(finished), 32'd1);

        @(posedge clk); #1;
        start = 1'b0;
        ofifo_valid = 1'b1;
        @(negedge clk);
        check("post_idle", 32'({ofifo_rd, pmem_wen, busy, done}), 32'd0);
        check("writes_left", 32'(exp_addr_q.size()), 32'd0);
`ifdef SFU_SEQ_CTRL_PERF_EN
        check("perf_stall", perf_stall, 32'(stalls));
`endif
        ofifo_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;

        // Accumulate kpos=3 npix=2, FIFO always ready.
        run(1'b0, 3, 2, 'h010, 0, 0, 0, 1'b0, 0);
        // Same with a 3-cycle gap after the 2nd pop; ReLU gives 7 then 0.
        dir_psum = '{5, -2, 4, -8, 1, 2};
        run(1'b0, 3, 2, 'h010, 0, 2, 3, 1'b0, 0);
        dir_psum.delete();
        // Bypass with address wrap-around.
        run(1'b1, 1, 3, 'h7FE, 0, 0, 0, 1'b0, 0);
        // Empty run and kpos=0 treated as 1.
        run(1'b0, 3, 0, 'h123, 0, 0, 0, 1'b0, 0);
        run(1'b0, 0, 2, 'h040, 20, 0, 0, 1'b0, 0);
        // Reset after the 4th pop of a kpos=3 npix=4 run.
        run(1'b0, 3, 4, 'h100, 0, 0, 0, 1'b0, 4);
        // Starts while busy (mid-run and in the done cycle) are ignored.
        run(1'b0, 2, 3, 'h200, 10, 0, 0, 1'b1, 0);
        // Five inserted empty cycles for the stall counter, then a fresh start.
        run(1'b0, 3, 2, 'h020, 0, 1, 5, 1'b0, 0);
        run(1'b1, 2, 2, 'h030, 0, 0, 0, 1'b0, 0);

        for (int r = 0; r < 10; r++)
            run(1'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 2047)), int'($urandom_range(0, 50)), 0, 0,
                1'($urandom), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
